oled_cmd_sequencer: RTL and testbench

Upstream command source for the I2C byte engine (address/control/data/op_start/op_done interface). After reset it streams the fixed SSD1306 power-up sequence, one command byte per I2C transaction. It then toggles display inversion periodically, which produces the blink. It runs on a single system clock and synchronises op_done, which the engine produces in its own clock domain.

---
 rtl/oled_pkg.sv | 49 ++++
 rtl/oled_init_rom.sv | 44 ++++
 rtl/oled_cmd_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_oled_cmd_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1306 command sequencer: command byte constants,
// init sequence length, FSM state encoding and the blink byte helper.
package oled_pkg;

  localparam int unsigned INIT_LEN = 25;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned BYTE_W   = 8;

  // SSD1306 command and argument bytes
  localparam logic [7:0] CMD_DISP_OFF      = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON       = 8'hAF;
  localparam logic [7:0] CMD_NORM          = 8'hA6;
  localparam logic [7:0] CMD_INV           = 8'hA7;
  localparam logic [7:0] CMD_CLK_DIV       = 8'hD5;
  localparam logic [7:0] ARG_CLK_DIV       = 8'h80;
  localparam logic [7:0] CMD_MUX_RATIO     = 8'hA8;
  localparam logic [7:0] ARG_MUX_64        = 8'h3F;
  localparam logic [7:0] CMD_DISP_OFFSET   = 8'hD3;
  localparam logic [7:0] ARG_ZERO          = 8'h00;
  localparam logic [7:0] CMD_START_LINE    = 8'h40;
  localparam logic [7:0] CMD_CHARGE_PUMP   = 8'h8D;
  localparam logic [7:0] ARG_PUMP_ON       = 8'h14;
  localparam logic [7:0] CMD_MEM_MODE      = 8'h20;
  localparam logic [7:0] CMD_SEG_REMAP     = 8'hA1;
  localparam logic [7:0] CMD_COM_SCAN_DEC  = 8'hC8;
  localparam logic [7:0] CMD_COM_PINS      = 8'hDA;
  localparam logic [7:0] ARG_COM_PINS      = 8'h12;
  localparam logic [7:0] CMD_CONTRAST      = 8'h81;
  localparam logic [7:0] ARG_CONTRAST      = 8'hCF;
  localparam logic [7:0] CMD_PRECHARGE     = 8'hD9;
  localparam logic [7:0] ARG_PRECHARGE     = 8'hF1;
  localparam logic [7:0] CMD_VCOMH         = 8'hDB;
  localparam logic [7:0] ARG_VCOMH         = 8'h40;
  localparam logic [7:0] CMD_RESUME_RAM    = 8'hA4;
  localparam logic [7:0] CMD_NOP           = 8'hE3;
  localparam logic [7:0] CTRL_CMD_STREAM   = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Next blink command: invert when currently normal, and vice versa
  function automatic logic [7:0] blink_cmd(input logic inv);
    return inv ? CMD_NORM : CMD_INV;
  endfunction

endpackage

// File: rtl/oled_init_rom.sv
// SSD1306 power-up command table.
// Ports:
//   i_idx   - 5-bit sequence index
//   o_cmd_c - command byte at that index (combinational); unused slots return NOP
module oled_init_rom
  import oled_pkg::*;
(
  input  logic [IDX_W-1:0]  i_idx,
  output logic [BYTE_W-1:0] o_cmd_c
);

  always_comb begin
    o_cmd_c = CMD_NOP;
    case (i_idx)
      5'd0:  o_cmd_c = CMD_DISP_OFF;
      5'd1:  o_cmd_c = CMD_CLK_DIV;
      5'd2:  o_cmd_c = ARG_CLK_DIV;
      5'd3:  o_cmd_c = CMD_MUX_RATIO;
      5'd4:  o_cmd_c = ARG_MUX_64;
      5'd5:  o_cmd_c = CMD_DISP_OFFSET;
      5'd6:  o_cmd_c = ARG_ZERO;
      5'd7:  o_cmd_c = CMD_START_LINE;
      5'd8:  o_cmd_c = CMD_CHARGE_PUMP;
      5'd9:  o_cmd_c = ARG_PUMP_ON;
      5'd10: o_cmd_c = CMD_MEM_MODE;
      5'd11: o_cmd_c = ARG_ZERO;
      5'd12: o_cmd_c = CMD_SEG_REMAP;
      5'd13: o_cmd_c = CMD_COM_SCAN_DEC;
      5'd14: o_cmd_c = CMD_COM_PINS;
      5'd15: o_cmd_c = ARG_COM_PINS;
      5'd16: o_cmd_c = CMD_CONTRAST;
      5'd17: o_cmd_c = ARG_CONTRAST;
      5'd18: o_cmd_c = CMD_PRECHARGE;
      5'd19: o_cmd_c = ARG_PRECHARGE;
      5'd20: o_cmd_c = CMD_VCOMH;
      5'd21: o_cmd_c = ARG_VCOMH;
      5'd22: o_cmd_c = CMD_RESUME_RAM;
      5'd23: o_cmd_c = CMD_NORM;
      5'd24: o_cmd_c = CMD_DISP_ON;
      default: o_cmd_c = CMD_NOP;
    endcase
  end

endmodule

// File: rtl/oled_cmd_sequencer.sv
// Command source for the I2C byte engine. Streams the SSD1306 power-up
// sequence one byte per transaction, then alternates INV/NORM to blink.
// Ports:
//   clk, rst_n   - system clock, async active-low reset
//   enable       - run permission, sampled in S_IDLE only
//   op_done      - engine completion pulse from the engine clock domain
//   address      - constant I2C write address
//   control      - constant command-stream control byte
//   data         - current command byte, stable while op_start is high
//   op_start     - transaction request
//   init_done    - all init bytes acknowledged
//   inverted     - 1 once INV was last acknowledged
//   timeout_err  - sticky op_done timeout flag
module oled_cmd_sequencer
  import oled_pkg::*;
#(
  parameter logic [7:0]  I2C_ADDR       = 8'h78,
  parameter logic [23:0] BLINK_PERIOD   = 24'd6_000_000,
  parameter logic [7:0]  GAP_CYCLES     = 8'd16,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       op_done,
  output logic [7:0] address,
  output logic [7:0] control,
  output logic [7:0] data,
  output logic       op_start,
  output logic       init_done,
  output logic       inverted,
  output logic       timeout_err
);

  localparam int unsigned TO_W    = 20;
  localparam int unsigned GAP_W   = 8;
  localparam int unsigned BLINK_W = 24;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INIT_LEN - 1);

  state_t               r_state;
  logic [IDX_W-1:0]     r_rom_idx;
  logic [TO_W-1:0]      r_to_cnt;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic [BLINK_W-1:0]   r_blink_cnt;
  logic                 r_op_start;
  logic [BYTE_W-1:0]    r_data;
  logic                 r_init_done;
  logic                 r_inverted;
  logic                 r_timeout_err;
  logic                 r_done_meta;
  logic                 r_done_sync;
  logic                 r_done_prev;

  state_t               w_state_nxt;
  logic [IDX_W-1:0]     w_rom_idx_nxt;
  logic [TO_W-1:0]      w_to_cnt_nxt;
  logic [GAP_W-1:0]     w_gap_cnt_nxt;
  logic [BLINK_W-1:0]   w_blink_cnt_nxt;
  logic                 w_op_start_nxt;
  logic [BYTE_W-1:0]    w_data_nxt;
  logic                 w_init_done_nxt;
  logic                 w_inverted_nxt;
  logic                 w_timeout_err_nxt;
  logic [BYTE_W-1:0]    w_rom_cmd;
  logic                 w_done_pulse;

  assign address     = I2C_ADDR;
  assign control     = CTRL_CMD_STREAM;
  assign data        = r_data;
  assign op_start    = r_op_start;
  assign init_done   = r_init_done;
  assign inverted    = r_inverted;
  assign timeout_err = r_timeout_err;

  oled_init_rom u_rom (
    .i_idx   (r_rom_idx),
    .o_cmd_c (w_rom_cmd)
  );

  // op_done crosses in from the engine domain: 2-flop sync plus rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_meta <= 1'b0;
      r_done_sync <= 1'b0;
      r_done_prev <= 1'b0;
    end else begin
      r_done_meta <= op_done;
      r_done_sync <= r_done_meta;
      r_done_prev <= r_done_sync;
    end
  end

  assign w_done_pulse = r_done_sync & ~r_done_prev;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rom_idx     <= '0;
      r_to_cnt      <= '0;
      r_gap_cnt     <= '0;
      r_blink_cnt   <= '0;
      r_op_start    <= 1'b0;
      r_data        <= CMD_DISP_OFF;
      r_init_done   <= 1'b0;
      r_inverted    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rom_idx     <= w_rom_idx_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
      r_blink_cnt   <= w_blink_cnt_nxt;
      r_op_start    <= w_op_start_nxt;
      r_data        <= w_data_nxt;
      r_init_done   <= w_init_done_nxt;
      r_inverted    <= w_inverted_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_rom_idx_nxt     = r_rom_idx;
    w_to_cnt_nxt      = r_to_cnt;
    w_gap_cnt_nxt     = r_gap_cnt;
    w_blink_cnt_nxt   = r_blink_cnt;
    w_op_start_nxt    = 1'b0;
    w_data_nxt        = r_data;
    w_init_done_nxt   = r_init_done;
    w_inverted_nxt    = r_inverted;
    w_timeout_err_nxt = r_timeout_err;

    case (r_state)
      S_IDLE: begin
        // Blink countdown only runs between transactions
        if (r_blink_cnt != '0) begin
          w_blink_cnt_nxt = r_blink_cnt - BLINK_W'(1);
        end
        if (enable && (!r_init_done || (r_blink_cnt == '0))) begin
          w_data_nxt     = r_init_done ? blink_cmd(r_inverted) : w_rom_cmd;
          w_op_start_nxt = 1'b1;
          w_to_cnt_nxt   = '0;
          w_state_nxt    = S_SEND;
        end
      end

      S_SEND: begin
        w_op_start_nxt = 1'b1;
        if (w_done_pulse) begin
          w_op_start_nxt = 1'b0;
          w_gap_cnt_nxt  = '0;
          w_state_nxt    = S_GAP;
          if (!r_init_done) begin
            // Index stops at the last entry instead of wrapping
            if (r_rom_idx == LAST_IDX) begin
              w_init_done_nxt = 1'b1;
            end else begin
              w_rom_idx_nxt = r_rom_idx + IDX_W'(1);
            end
          end else begin
            w_inverted_nxt  = ~r_inverted;
            w_blink_cnt_nxt = BLINK_PERIOD;
          end
        end else if (r_to_cnt == (TIMEOUT_CYCLES - TO_W'(1))) begin
          // Abandon without advancing so the same byte is retried
          w_op_start_nxt    = 1'b0;
          w_timeout_err_nxt = 1'b1;
          w_gap_cnt_nxt     = '0;
          w_state_nxt       = S_GAP;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
      end

      S_GAP: begin
        if (r_gap_cnt == (GAP_CYCLES - GAP_W'(1))) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oled_cmd_sequencer.sv
// Bench for oled_cmd_sequencer: an engine model acks requests after 40 clk,
// a monitor pops expected bytes from a queue on every op_start rise.
module tb_oled_cmd_sequencer;

  localparam int GAP         = 4;
  localparam int BLINK       = 100;
  localparam int TMO         = 200;
  localparam int ACK_DELAY   = 40;
  localparam int ACK_WIDTH   = 4;
  localparam int WAIT_BUDGET = 4000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       op_done;
  logic [7:0] address, control, data;
  logic       op_start, init_done, inverted, timeout_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] init_seq [0:24] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};

  // Engine model controls
  logic       withhold_en = 1'b0;
  logic [7:0] withhold_byte = 8'h00;
  logic       spur_on_fall = 1'b0;
  logic       spur_req = 1'b0;

  oled_cmd_sequencer #(
    .I2C_ADDR       (8'h78),
    .BLINK_PERIOD   (24'd100),
    .GAP_CYCLES     (8'd4),
    .TIMEOUT_CYCLES (20'd200)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .op_done     (op_done),
    .address     (address),
    .control     (control),
    .data        (data),
    .op_start    (op_start),
    .init_done   (init_done),
    .inverted    (inverted),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Engine model: ack each request after ACK_DELAY clk with a ACK_WIDTH-clk pulse
  initial begin : engine
    op_done = 1'b0;
    forever begin
      @(negedge clk);
      if (spur_req) begin
        op_done = 1'b1;
        repeat (ACK_WIDTH) @(negedge clk);
        op_done = 1'b0;
        spur_req = 1'b0;
      end else if (op_start === 1'b1) begin
        if (withhold_en && data == withhold_byte) begin
          withhold_en = 1'b0;
          while (op_start === 1'b1) @(negedge clk);
          if (spur_on_fall) begin
            op_done = 1'b1;
            @(negedge clk);
            op_done = 1'b0;
            spur_on_fall = 1'b0;
          end
        end else begin
          for (int i = 0; i < ACK_DELAY - 1 && op_start === 1'b1; i++) @(negedge clk);
          if (op_start === 1'b1) begin
            op_done = 1'b1;
            repeat (ACK_WIDTH) @(negedge clk);
            op_done = 1'b0;
            checks++;
            if (op_start !== 1'b0) begin
              failures++;
              $display("FAIL ack_release: op_start=%b when op_done cleared, expected 0", op_start);
            end
          end
        end
      end
    end
  end

  // Scoreboard monitor: byte order, data stability and gap spacing
  logic       mon_prev_start = 1'b0;
  logic [7:0] mon_prev_data = 8'h00;
  int         mon_gap_left = 0;
  logic [7:0] mon_exp;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        mon_prev_start = 1'b0;
        mon_gap_left = 0;
      end else begin
        if (mon_prev_start && op_start !== 1'b1) begin
          mon_gap_left = GAP;
        end else if (mon_gap_left > 0) begin
          checks++;
          if (op_start !== 1'b0) begin
            failures++;
            $display("FAIL gap_quiet: op_start=%b inside gap, expected 0", op_start);
          end
          mon_gap_left--;
        end
        if (op_start === 1'b1 && !mon_prev_start) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_extra: op_start with data=%02h, expected no transaction", data);
          end else begin
            mon_exp = exp_q.pop_front();
            if (data !== mon_exp) begin
              failures++;
              $display("FAIL sb_data: data=%02h expected %02h", data, mon_exp);
            end
          end
        end else if (op_start === 1'b1 && mon_prev_start) begin
          checks++;
          if (data !== mon_prev_data) begin
            failures++;
            $display("FAIL data_stable: data=%02h changed from %02h while op_start high", data, mon_prev_data);
          end
        end
        mon_prev_start = (op_start === 1'b1);
        mon_prev_data = data;
      end
    end
  end

  task automatic wait_send(input logic [7:0] b, input string tag);
    int n = 0;
    while (!(op_start === 1'b1 && data === b) && n < WAIT_BUDGET) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= WAIT_BUDGET) begin
      failures++;
      $display("FAIL %s: no op_start with data %02h within %0d clk", tag, b, WAIT_BUDGET);
    end
  endtask

  task automatic wait_fall(input string tag);
    int n = 0;
    while (op_start !== 1'b0 && n < WAIT_BUDGET) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= WAIT_BUDGET) begin
      failures++;
      $display("FAIL %s: op_start=%b after %0d clk, expected 0", tag, op_start, WAIT_BUDGET);
    end
  endtask

  task automatic test_reset();
    int n_hi = 0;
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (op_start !== 1'b0) begin failures++; $display("FAIL rst_op_start: got %b expected 0", op_start); end
    checks++; if (data !== 8'hAE) begin failures++; $display("FAIL rst_data: got %02h expected AE", data); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL rst_init_done: got %b expected 0", init_done); end
    checks++; if (inverted !== 1'b0) begin failures++; $display("FAIL rst_inverted: got %b expected 0", inverted); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_timeout_err: got %b expected 0", timeout_err); end
    checks++; if (address !== 8'h78) begin failures++; $display("FAIL rst_address: got %02h expected 78", address); end
    checks++; if (control !== 8'h00) begin failures++; $display("FAIL rst_control: got %02h expected 00", control); end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (op_start !== 1'b0) n_hi++;
    end
    checks++; if (n_hi != 0) begin failures++; $display("FAIL idle_disabled: op_start high %0d clk, expected 0", n_hi); end
  endtask

  task automatic test_timeout();
    int n = 0;
    exp_q.push_back(init_seq[0]);
    exp_q.push_back(init_seq[1]);
    exp_q.push_back(init_seq[2]);
    exp_q.push_back(init_seq[2]);
    withhold_byte = 8'h80;
    withhold_en = 1'b1;
    spur_on_fall = 1'b1;
    enable = 1'b1;
    wait_send(8'h80, "timeout_first_send");
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_early: timeout_err=%b expected 0", timeout_err); end
    while (op_start === 1'b1 && n < WAIT_BUDGET) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != TMO) begin failures++; $display("FAIL timeout_len: op_start high %0d clk, expected %0d", n, TMO); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_flag: got %b expected 1", timeout_err); end
    wait_send(8'h80, "timeout_resend");
    wait_fall("timeout_resend_ack");
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %b expected 1", timeout_err); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL timeout_init_done: got %b expected 0", init_done); end
  endtask

  task automatic test_enable_mid();
    int n_hi = 0;
    for (int i = 3; i <= 9; i++) exp_q.push_back(init_seq[i]);
    wait_send(8'h14, "enable_byte10");
    enable = 1'b0;
    wait_fall("enable_byte10_ack");
    repeat (60) begin
      @(negedge clk);
      if (op_start !== 1'b0) n_hi++;
    end
    spur_req = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (op_start !== 1'b0) n_hi++;
    end
    checks++; if (n_hi != 0) begin failures++; $display("FAIL enable_park: op_start high %0d clk, expected 0", n_hi); end
    checks++; if (data !== 8'h14) begin failures++; $display("FAIL enable_hold: data=%02h expected 14", data); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL enable_pending: %0d bytes unsent, expected 0", exp_q.size()); end
    exp_q.push_back(init_seq[10]);
    enable = 1'b1;
    wait_send(8'h20, "enable_resume");
  endtask

  task automatic test_reset_mid();
    for (int i = 11; i <= 14; i++) exp_q.push_back(init_seq[i]);
    wait_send(8'hDA, "reset_byte15");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (op_start !== 1'b0) begin failures++; $display("FAIL reset_async: op_start=%b expected 0", op_start); end
    @(negedge clk);
    repeat (2) @(negedge clk);
    checks++; if (data !== 8'hAE) begin failures++; $display("FAIL reset_mid_data: got %02h expected AE", data); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_mid_terr: got %b expected 0", timeout_err); end
    checks++; if (init_done !== 1'b0 || inverted !== 1'b0) begin failures++; $display("FAIL reset_mid_flags: init_done=%b inverted=%b expected 0 0", init_done, inverted); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL reset_mid_pending: %0d bytes unsent, expected 0", exp_q.size()); end
    for (int i = 0; i < 25; i++) exp_q.push_back(init_seq[i]);
    exp_q.push_back(8'hA7);
    exp_q.push_back(8'hA6);
    exp_q.push_back(8'hA7);
    rst_n = 1'b1;
  endtask

  task automatic test_full_init();
    wait_send(8'hAF, "init_last");
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL init_done_early: got %b expected 0", init_done); end
    wait_fall("init_last_ack");
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL init_done_set: got %b expected 1", init_done); end
    checks++; if (inverted !== 1'b0) begin failures++; $display("FAIL init_inverted: got %b expected 0", inverted); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL init_terr: got %b expected 0", timeout_err); end
  endtask

  task automatic test_blink();
    int n;
    wait_send(8'hA7, "blink_first");
    wait_fall("blink_first_ack");
    checks++; if (inverted !== 1'b1) begin failures++; $display("FAIL blink_inv1: got %b expected 1", inverted); end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (op_start !== 1'b1 && n < WAIT_BUDGET) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n < BLINK + GAP + 1 - 2 || n > BLINK + GAP + 1 + 2) begin
        failures++;
        $display("FAIL blink_spacing%0d: %0d clk, expected %0d +-2", k, n, BLINK + GAP + 1);
      end
      checks++;
      if (data !== ((k == 0) ? 8'hA6 : 8'hA7)) begin
        failures++;
        $display("FAIL blink_byte%0d: data=%02h expected %02h", k, data, (k == 0) ? 8'hA6 : 8'hA7);
      end
      wait_fall("blink_ack");
      checks++;
      if (inverted !== ((k == 0) ? 1'b0 : 1'b1)) begin
        failures++;
        $display("FAIL blink_inv_toggle%0d: got %b expected %b", k, inverted, (k == 0) ? 1'b0 : 1'b1);
      end
    end
    enable = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL blink_pending: %0d bytes unsent, expected 0", exp_q.size()); end
  endtask

  initial begin : main
    test_reset();
    test_timeout();
    test_enable_mid();
    test_reset_mid();
    test_full_init();
    test_blink();
    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
